// File: rtl/fixed_point_pkg.sv
// Q1.15 fixed-point types and helpers shared by the state-vector datapath.
package fixed_point_pkg;

    localparam int unsigned Q15_W  = 16;
    localparam int unsigned WIDE_W = 17;
    localparam int unsigned ACC_W  = 19;

    typedef logic signed [Q15_W-1:0]  q15_t;
    typedef logic signed [WIDE_W-1:0] q15_wide_t;
    typedef logic signed [ACC_W-1:0]  q15_acc_t;

    typedef struct packed {
        q15_t re;
        q15_t im;
    } cplx_q15_t;

    typedef enum logic [1:0] {
        ST_NOGATE = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2
    } gate_state_e;

    localparam q15_acc_t Q15_MAX_ACC = 19'sd32767;
    localparam q15_acc_t Q15_MIN_ACC = -19'sd32768;

    // Q1.15 product, arithmetic shift by 15 (floor); 17 bits so (-1)*(-1) = +1.0 survives
    function automatic q15_wide_t mul_q15_wide(input q15_t a, input q15_t b);
        logic signed [2*Q15_W-1:0] p;
        p = a * b;
        return p[WIDE_W+14:15];
    endfunction

    // True when a wide sum lies outside the Q1.15 range
    function automatic logic q15_overflows(input q15_acc_t x);
        return (x > Q15_MAX_ACC) || (x < Q15_MIN_ACC);
    endfunction

    // Clamp a wide sum to [-32768, 32767]
    function automatic q15_t sat_q15(input q15_acc_t x);
        if (x > Q15_MAX_ACC) begin
            return 16'h7FFF;
        end
        if (x < Q15_MIN_ACC) begin
            return 16'h8000;
        end
        return x[Q15_W-1:0];
    endfunction

endpackage

// File: rtl/cmac_q15.sv
// Complex two-term dot product y = c0*a0 + c1*a1 in Q1.15.
// S1 registers the eight real partial products, S2 the saturated sums.
module cmac_q15
    import fixed_point_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    input  cplx_q15_t c0,
    input  cplx_q15_t c1,
    input  cplx_q15_t a0,
    input  cplx_q15_t a1,
    output cplx_q15_t y,
    output logic      sat
);

    q15_wide_t prod_d [8];
    q15_wide_t prod_q [8];
    q15_acc_t  re_sum;
    q15_acc_t  im_sum;
    cplx_q15_t y_d;
    cplx_q15_t y_q;
    logic      sat_d;
    logic      sat_q;

    // Partial products: [0..3] feed the real part, [4..7] the imaginary part
    always_comb begin
        prod_d[0] = mul_q15_wide(c0.re, a0.re);
        prod_d[1] = mul_q15_wide(c0.im, a0.im);
        prod_d[2] = mul_q15_wide(c1.re, a1.re);
        prod_d[3] = mul_q15_wide(c1.im, a1.im);
        prod_d[4] = mul_q15_wide(c0.re, a0.im);
        prod_d[5] = mul_q15_wide(c0.im, a0.re);
        prod_d[6] = mul_q15_wide(c1.re, a1.im);
        prod_d[7] = mul_q15_wide(c1.im, a1.re);
    end

    // Wide accumulation of the registered products, then clamp and flag overflow
    always_comb begin
        re_sum = q15_acc_t'(prod_q[0]) - q15_acc_t'(prod_q[1])
               + q15_acc_t'(prod_q[2]) - q15_acc_t'(prod_q[3]);
        im_sum = q15_acc_t'(prod_q[4]) + q15_acc_t'(prod_q[5])
               + q15_acc_t'(prod_q[6]) + q15_acc_t'(prod_q[7]);
        y_d.re = sat_q15(re_sum);
        y_d.im = sat_q15(im_sum);
        sat_d  = q15_overflows(re_sum) || q15_overflows(im_sum);
    end

    // Both stages advance together and freeze when the pipeline stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 8; i++) begin
                prod_q[i] <= '0;
            end
            y_q   <= '0;
            sat_q <= 1'b0;
        end else if (en) begin
            for (int unsigned i = 0; i < 8; i++) begin
                prod_q[i] <= prod_d[i];
            end
            y_q   <= y_d;
            sat_q <= sat_d;
        end
    end

    assign y   = y_q;
    assign sat = sat_q;

endmodule

// File: rtl/qc_gate_apply.sv
// Streaming single-qubit gate unit: (b0, b1) = U * (a0, a1) in Q1.15.
// Holds one 2x2 unitary; a gate swap drains the pipeline before relatching.
module qc_gate_apply
    import fixed_point_pkg::*;
#(
    parameter int unsigned LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             g_valid,
    output logic             g_ready,
    input  logic [7:0][15:0] g_coef,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0][15:0] in_amp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0][15:0] out_amp,
    output logic             sat_flag,
    output logic [31:0]      pair_cnt
);

    if (LAT != 3) begin : g_lat_check
        $error("qc_gate_apply: LAT must be 3");
    end

    gate_state_e      state_q, state_d;
    logic [7:0][15:0] coef_q, coef_d;
    logic             v1_q, v1_d;
    logic             v2_q, v2_d;
    logic             out_valid_q, out_valid_d;
    logic [3:0][15:0] out_amp_q, out_amp_d;
    logic             sat_flag_q, sat_flag_d;
    logic [31:0]      pair_cnt_q, pair_cnt_d;

    logic             adv;
    logic             pipe_empty;
    logic             g_fire;
    logic             in_fire;
    logic             out_fire;

    cplx_q15_t        u00, u01, u10, u11;
    cplx_q15_t        a0, a1;
    cplx_q15_t        b0, b1;
    logic             b0_sat, b1_sat;

    // Handshakes and global advance; coefficients may only load with the pipeline empty
    always_comb begin
        adv        = !out_valid_q || out_ready;
        pipe_empty = !v1_q && !v2_q && !out_valid_q;
        g_ready    = (state_q == ST_NOGATE) || ((state_q == ST_DRAIN) && pipe_empty);
        in_ready   = (state_q == ST_RUN) && adv;
        g_fire     = g_valid && g_ready;
        in_fire    = in_valid && in_ready;
        out_fire   = out_valid_q && out_ready;
    end

    // Unpack latched coefficients and incoming amplitudes into complex operands
    always_comb begin
        u00 = cplx_q15_t'({coef_q[0], coef_q[1]});
        u01 = cplx_q15_t'({coef_q[2], coef_q[3]});
        u10 = cplx_q15_t'({coef_q[4], coef_q[5]});
        u11 = cplx_q15_t'({coef_q[6], coef_q[7]});
        a0  = cplx_q15_t'({in_amp[0], in_amp[1]});
        a1  = cplx_q15_t'({in_amp[2], in_amp[3]});
    end

    cmac_q15 u_cmac_b0 (
        .clk (clk),
        .rst (rst),
        .en  (adv),
        .c0  (u00),
        .c1  (u01),
        .a0  (a0),
        .a1  (a1),
        .y   (b0),
        .sat (b0_sat)
    );

    cmac_q15 u_cmac_b1 (
        .clk (clk),
        .rst (rst),
        .en  (adv),
        .c0  (u10),
        .c1  (u11),
        .a0  (a0),
        .a1  (a1),
        .y   (b1),
        .sat (b1_sat)
    );

    // Next-state for the gate FSM, valid pipeline, output register and status
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_NOGATE: if (g_fire)     state_d = ST_RUN;
            ST_RUN:    if (g_valid)    state_d = ST_DRAIN;
            ST_DRAIN:  if (pipe_empty) state_d = ST_RUN;
            default:                   state_d = ST_NOGATE;
        endcase

        coef_d      = g_fire ? g_coef : coef_q;

        v1_d        = adv ? in_fire     : v1_q;
        v2_d        = adv ? v1_q        : v2_q;
        out_valid_d = adv ? v2_q        : out_valid_q;

        out_amp_d   = out_amp_q;
        sat_flag_d  = sat_flag_q;
        if (adv && v2_q) begin
            out_amp_d  = {b1.im, b1.re, b0.im, b0.re};
            sat_flag_d = sat_flag_q || b0_sat || b1_sat;
        end

        pair_cnt_d  = out_fire ? pair_cnt_q + 32'd1 : pair_cnt_q;
    end

    // All control and output state; reset forgets the gate and discards in-flight pairs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_NOGATE;
            coef_q      <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_amp_q   <= '0;
            sat_flag_q  <= 1'b0;
            pair_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            coef_q      <= coef_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            out_valid_q <= out_valid_d;
            out_amp_q   <= out_amp_d;
            sat_flag_q  <= sat_flag_d;
            pair_cnt_q  <= pair_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_amp   = out_amp_q;
    assign sat_flag  = sat_flag_q;
    assign pair_cnt  = pair_cnt_q;

endmodule

// File: tb/tb_qc_gate_apply.sv
// Scoreboard bench for qc_gate_apply: stimulus pushes expected outputs,
// a negedge monitor pops and compares on every output handshake.
module tb_qc_gate_apply;

    logic             clk = 1'b0;
    logic             rst;
    logic             g_valid;
    logic             g_ready;
    logic [7:0][15:0] g_coef;
    logic             in_valid;
    logic             in_ready;
    logic [3:0][15:0] in_amp;
    logic             out_valid;
    logic             out_ready;
    logic [3:0][15:0] out_amp;
    logic             sat_flag;
    logic [31:0]      pair_cnt;

    int unsigned      n_tests = 0;
    int unsigned      n_fail  = 0;
    logic [63:0]      exp_q [$];

    logic             fixed_ready = 1'b1;
    logic             rand_en     = 1'b0;
    logic             rnd_ready   = 1'b1;

    assign out_ready = rand_en ? rnd_ready : fixed_ready;

    always #5 clk = ~clk;

    qc_gate_apply #(.LAT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .g_valid   (g_valid),
        .g_ready   (g_ready),
        .g_coef    (g_coef),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_amp    (in_amp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_amp   (out_amp),
        .sat_flag  (sat_flag),
        .pair_cnt  (pair_cnt)
    );

    function automatic logic [127:0] mk_gate(input logic [15:0] u00re, u00im, u01re, u01im,
                                             input logic [15:0] u10re, u10im, u11re, u11im);
        return {u11im, u11re, u10im, u10re, u01im, u01re, u00im, u00re};
    endfunction

    function automatic logic [63:0] mk_amp(input logic [15:0] a0re, a0im, a1re, a1im);
        return {a1im, a1re, a0im, a0re};
    endfunction

    // Identity-gate reference per component: (x * 0x7FFF) >>> 15
    function automatic logic [15:0] ident(input logic [15:0] x);
        logic signed [31:0] p;
        p = $signed(x) * 32'sd32767;
        p = p >>> 15;
        return p[15:0];
    endfunction

    function automatic logic [63:0] ident_exp(input logic [63:0] a);
        return {ident(a[63:48]), ident(a[47:32]), ident(a[31:16]), ident(a[15:0])};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Random output backpressure
    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: compare every output handshake against the scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got %h, want no output", out_amp);
            end else begin
                check("out_amp", out_amp, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [63:0] a, input logic [63:0] e);
        int unsigned t = 0;
        in_amp   = a;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (in_ready) begin
            exp_q.push_back(e);
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0, want 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic load_gate(input logic [127:0] c);
        int unsigned t = 0;
        g_coef  = c;
        g_valid = 1'b1;
        @(negedge clk);
        while (!g_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!g_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL gate_timeout: got g_ready=0, want 1");
        end
        @(posedge clk);
        #1;
        g_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int unsigned t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0 || out_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] gate_h, gate_s1, gate_s2, gate_id;
        logic [63:0]  sv [4];
        logic [63:0]  se [4];
        logic [63:0]  a;
        int unsigned  cnt;
        int unsigned  acc;
        int unsigned  t;

        gate_h  = mk_gate(16'h5A82, 16'h0, 16'h5A82, 16'h0, 16'h5A82, 16'h0, 16'hA57E, 16'h0);
        gate_s1 = mk_gate(16'h7FFF, 16'h0, 16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        gate_s2 = mk_gate(16'h8000, 16'h0, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        gate_id = mk_gate(16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h7FFF, 16'h0);

        sv[0] = mk_amp(16'h7FFF, 16'hFFFE, 16'h0001, 16'h0002); se[0] = 64'h0001_0000_FFFE_7FFE;
        sv[1] = mk_amp(16'h4000, 16'h0000, 16'h0000, 16'h0000); se[1] = 64'h0000_0000_0000_3FFF;
        sv[2] = mk_amp(16'h0000, 16'h0000, 16'h0000, 16'h8000); se[2] = 64'h8001_0000_0000_0000;
        sv[3] = mk_amp(16'hC000, 16'h0000, 16'h0000, 16'h0000); se[3] = 64'h0000_0000_0000_C000;

        rst      = 1'b1;
        g_valid  = 1'b0;
        g_coef   = '0;
        in_valid = 1'b0;
        in_amp   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_out_amp",   out_amp,            64'd0);
        check("rst_in_ready",  {63'b0, in_ready},  64'd0);
        check("rst_g_ready",   {63'b0, g_ready},   64'd1);
        check("rst_sat_flag",  {63'b0, sat_flag},  64'd0);
        check("rst_pair_cnt",  {32'b0, pair_cnt},  64'd0);
        @(posedge clk);
        #1;

        // Hadamard, including the three-cycle latency
        load_gate(gate_h);
        send(mk_amp(16'h7FFF, 16'h0, 16'h0, 16'h0), 64'h0000_5A81_0000_5A81);
        cnt = 0;
        while (!out_valid && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check("hadamard_latency", 64'(cnt), 64'd3);
        @(posedge clk);
        #1;
        send(mk_amp(16'h0, 16'h0, 16'h7FFF, 16'h0), 64'h0000_A57E_0000_5A81);
        wait_drain();
        check("hadamard_no_sat", {63'b0, sat_flag}, 64'd0);

        // Saturation, positive and negative
        load_gate(gate_s1);
        send(mk_amp(16'h7FFF, 16'h0, 16'h7FFF, 16'h0), 64'h0000_0000_0000_7FFF);
        wait_drain();
        check("sat_flag_set", {63'b0, sat_flag}, 64'd1);
        load_gate(gate_s2);
        send(mk_amp(16'h8000, 16'h0, 16'h0, 16'h0), 64'h0000_0000_0000_7FFF);
        send(mk_amp(16'h7FFF, 16'h0, 16'h7FFF, 16'h0), 64'h0000_0000_0000_8000);
        wait_drain();

        // Gate swap mid-stream; the fifth pair shares its cycle with g_valid
        send(mk_amp(16'h0100, 16'h0200, 16'h0010, 16'h0020), 64'h0000_0000_FDE0_FEF0);
        send(mk_amp(16'h1000, 16'h0000, 16'h0000, 16'h0001), 64'h0000_0000_FFFF_F000);
        send(mk_amp(16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000), 64'h0000_0000_0000_0002);
        send(mk_amp(16'h8000, 16'h0000, 16'h8000, 16'h0000), 64'h0000_0000_0000_7FFF);
        g_coef  = gate_id;
        g_valid = 1'b1;
        send(mk_amp(16'h4000, 16'h4000, 16'h4000, 16'hC000), 64'h0000_0000_0000_8000);
        t = 0;
        @(negedge clk);
        while (!g_ready && t < 50) begin
            check("drain_in_ready", {63'b0, in_ready}, 64'd0);
            @(negedge clk);
            t++;
        end
        check("swap_g_ready", {63'b0, g_ready}, 64'd1);
        check("swap_old_done", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
        g_valid = 1'b0;
        @(negedge clk);
        check("g_ready_one_cycle", {63'b0, g_ready}, 64'd0);
        @(posedge clk);
        #1;
        send(mk_amp(16'h7FFF, 16'h8000, 16'h1234, 16'hFFFF), 64'hFFFF_1233_8001_7FFE);
        wait_drain();

        // Stall: output held off for ten cycles of continuous input
        fixed_ready = 1'b0;
        acc         = 0;
        in_amp      = sv[0];
        in_valid    = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) begin
                check("stall_hold", out_amp, se[0]);
            end
            if (in_ready) begin
                if (acc < 4) exp_q.push_back(se[acc]);
                acc++;
            end
            @(posedge clk);
            #1;
            if (acc < 4) in_amp = sv[acc];
        end
        in_valid = 1'b0;
        check("stall_accepted", 64'(acc), 64'd3);
        fixed_ready = 1'b1;
        wait_drain();

        // Reset with three pairs in flight
        send(sv[0], se[0]);
        send(sv[1], se[1]);
        send(sv[2], se[2]);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        check("midrst_in_ready",  {63'b0, in_ready},  64'd0);
        check("midrst_g_ready",   {63'b0, g_ready},   64'd1);
        check("midrst_pair_cnt",  {32'b0, pair_cnt},  64'd0);
        check("midrst_sat_flag",  {63'b0, sat_flag},  64'd0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Identity gate, 1000 random pairs under random backpressure
        load_gate(gate_id);
        rand_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a = {$urandom, $urandom};
            send(a, ident_exp(a));
        end
        wait_drain();
        rand_en = 1'b0;
        check("ident_pair_cnt", {32'b0, pair_cnt}, 64'd1000);
        check("ident_no_sat",   {63'b0, sat_flag}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
